// File: rtl/dcache_controller.sv
// Direct-mapped, write-through, write-no-allocate data cache between the CPU
// load/store port and a block-refill main memory, with hit/miss counters.
module dcache_controller #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 10,
  parameter int LINES      = 32
) (
  input  logic                  CLK,
  input  logic                  rst_n,
  input  logic                  Cpu_Rd,
  input  logic                  Cpu_Wr,
  input  logic [ADDR_WIDTH-1:0] Cpu_Addr,
  input  logic [DATA_WIDTH-1:0] Cpu_WData,
  output logic [DATA_WIDTH-1:0] Cpu_RData,
  output logic                  Stall,
  output logic                  Mem_Wr,
  output logic                  EnMain_Rd,
  output logic [ADDR_WIDTH-1:0] Mem_Addr,
  output logic [DATA_WIDTH-1:0] Mem_WData,
  input  logic [DATA_WIDTH-1:0] cache_in0,
  input  logic [DATA_WIDTH-1:0] cache_in1,
  input  logic [DATA_WIDTH-1:0] cache_in2,
  input  logic [DATA_WIDTH-1:0] cache_in3,
  input  logic                  Ready,
  output logic [15:0]           Hit_Count,
  output logic [15:0]           Miss_Count
);
  localparam int INDEX = $clog2(LINES);
  localparam int TAG   = ADDR_WIDTH - 2 - INDEX;

  typedef enum logic [1:0] {IDLE, RD_MISS, WR_THRU} state_t;

  state_t                  state_q, state_d;
  logic [LINES-1:0]        valid_q, valid_d;
  logic [15:0]             hit_cnt_q, hit_cnt_d;
  logic [15:0]             miss_cnt_q, miss_cnt_d;

  logic [TAG-1:0]          tag_mem [LINES];
  logic [1:0]              offset;
  logic [INDEX-1:0]        index;
  logic [TAG-1:0]          tag;
  logic                    hit;
  logic                    fill;
  logic                    word_upd;
  logic [DATA_WIDTH-1:0]   cache_in_w [4];
  logic [DATA_WIDTH-1:0]   line_word  [4];

  assign offset    = Cpu_Addr[1:0];
  assign index     = Cpu_Addr[INDEX+1:2];
  assign tag       = Cpu_Addr[ADDR_WIDTH-1:INDEX+2];
  assign hit       = valid_q[index] && (tag_mem[index] == tag);
  assign Mem_Addr  = Cpu_Addr;
  assign Mem_WData = Cpu_WData;
  assign Hit_Count  = hit_cnt_q;
  assign Miss_Count = miss_cnt_q;

  assign cache_in_w[0] = cache_in0;
  assign cache_in_w[1] = cache_in1;
  assign cache_in_w[2] = cache_in2;
  assign cache_in_w[3] = cache_in3;

  // One bank per word offset so a refill writes all four words in one cycle.
  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_bank
      logic [DATA_WIDTH-1:0] bank [LINES];
      always_ff @(posedge CLK) begin
        if (fill)
          bank[index] <= cache_in_w[gi];
        else if (word_upd && offset == 2'(gi))
          bank[index] <= Cpu_WData;
      end
      assign line_word[gi] = bank[index];
    end
  endgenerate

  always_ff @(posedge CLK) begin
    if (fill)
      tag_mem[index] <= tag;
  end

  always_comb begin
    state_d   = state_q;
    Stall     = 1'b0;
    Mem_Wr    = 1'b0;
    EnMain_Rd = 1'b0;
    Cpu_RData = line_word[offset];
    fill      = 1'b0;
    word_upd  = 1'b0;
    valid_d   = valid_q;
    hit_cnt_d  = hit_cnt_q;
    miss_cnt_d = miss_cnt_q;
    case (state_q)
      IDLE: begin
        if (Cpu_Wr) begin
          state_d = WR_THRU;
          Stall   = 1'b1;
        end else if (Cpu_Rd) begin
          if (hit) begin
            if (hit_cnt_q != 16'hFFFF) hit_cnt_d = hit_cnt_q + 16'd1;
          end else begin
            state_d = RD_MISS;
            Stall   = 1'b1;
            if (miss_cnt_q != 16'hFFFF) miss_cnt_d = miss_cnt_q + 16'd1;
          end
        end
      end
      RD_MISS: begin
        // Strobe drops in the Ready cycle so the memory op counter rewinds cleanly.
        EnMain_Rd = !Ready;
        if (Ready) begin
          fill           = 1'b1;
          valid_d[index] = 1'b1;
          Cpu_RData      = cache_in_w[offset];
          state_d        = IDLE;
        end else begin
          Stall = 1'b1;
        end
      end
      WR_THRU: begin
        Mem_Wr = !Ready;
        if (Ready) begin
          word_upd = hit;
          state_d  = IDLE;
        end else begin
          Stall = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      valid_q    <= '0;
      hit_cnt_q  <= '0;
      miss_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      valid_q    <= valid_d;
      hit_cnt_q  <= hit_cnt_d;
      miss_cnt_q <= miss_cnt_d;
    end
  end
endmodule

// File: tb/tb_dcache_controller.sv
// Directed bench for dcache_controller: a behavioural main memory, a read-data
// scoreboard drained by a monitor, and per-request stall/strobe checks.
module tb_dcache_controller;
  logic        CLK = 1'b0;
  logic        rst_n = 1'b0;
  logic        Cpu_Rd = 1'b0, Cpu_Wr = 1'b0;
  logic [9:0]  Cpu_Addr = '0;
  logic [31:0] Cpu_WData = '0;
  logic [31:0] Cpu_RData;
  logic        Stall, Mem_Wr, EnMain_Rd;
  logic [9:0]  Mem_Addr;
  logic [31:0] Mem_WData;
  logic [31:0] cache_in0, cache_in1, cache_in2, cache_in3;
  logic        Ready;
  logic [15:0] Hit_Count, Miss_Count;

  int compared = 0;
  int mismatched = 0;
  logic [31:0] exp_q [$];

  dcache_controller #(.DATA_WIDTH(32), .ADDR_WIDTH(10), .LINES(32)) dut (
    .CLK(CLK), .rst_n(rst_n), .Cpu_Rd(Cpu_Rd), .Cpu_Wr(Cpu_Wr),
    .Cpu_Addr(Cpu_Addr), .Cpu_WData(Cpu_WData), .Cpu_RData(Cpu_RData),
    .Stall(Stall), .Mem_Wr(Mem_Wr), .EnMain_Rd(EnMain_Rd),
    .Mem_Addr(Mem_Addr), .Mem_WData(Mem_WData),
    .cache_in0(cache_in0), .cache_in1(cache_in1), .cache_in2(cache_in2),
    .cache_in3(cache_in3), .Ready(Ready),
    .Hit_Count(Hit_Count), .Miss_Count(Miss_Count)
  );

  always #5 CLK = ~CLK;

  // Behavioural main memory: 2 strobe cycles per block read, 4 per word write,
  // then a one-cycle Ready pulse.
  logic [31:0] mem [1024];
  int          op_cnt;
  logic        ready_r;
  assign Ready = ready_r;
  assign cache_in0 = mem[{Mem_Addr[9:2], 2'd0}];
  assign cache_in1 = mem[{Mem_Addr[9:2], 2'd1}];
  assign cache_in2 = mem[{Mem_Addr[9:2], 2'd2}];
  assign cache_in3 = mem[{Mem_Addr[9:2], 2'd3}];

  always @(posedge CLK or negedge rst_n) begin
    if (!rst_n) begin
      op_cnt  <= 0;
      ready_r <= 1'b0;
    end else begin
      ready_r <= 1'b0;
      if (EnMain_Rd) begin
        if (op_cnt == 1) begin ready_r <= 1'b1; op_cnt <= 0; end
        else op_cnt <= op_cnt + 1;
      end else if (Mem_Wr) begin
        if (op_cnt == 3) begin
          ready_r <= 1'b1; op_cnt <= 0; mem[Mem_Addr] <= Mem_WData;
        end else op_cnt <= op_cnt + 1;
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Monitor: every completed load pops one expected word.
  always @(negedge CLK) begin
    if (rst_n && Cpu_Rd && !Stall) begin
      if (exp_q.size() == 0) begin
        compared++; mismatched++;
        $display("FAIL rdata_unexpected: got 0x%08h addr 0x%03h with empty scoreboard", Cpu_RData, Cpu_Addr);
      end else begin
        logic [31:0] e;
        e = exp_q.pop_front();
        check($sformatf("rdata@%03h", Cpu_Addr), Cpu_RData, e);
      end
    end
  end

  // Issue one request, hold it until Stall drops, and check stall/strobe timing.
  task automatic request(input bit wr, input logic [9:0] addr, input logic [31:0] wdata,
                         input logic [31:0] exp_data, input int exp_stall, input int exp_strobe);
    int stalls = 0, strobes = 0, wrong = 0;
    bit done = 0;
    if (!wr) exp_q.push_back(exp_data);
    Cpu_Addr = addr; Cpu_WData = wdata; Cpu_Wr = wr; Cpu_Rd = !wr;
    for (int c = 0; c < 20 && !done; c++) begin
      @(negedge CLK);
      if (wr ? Mem_Wr : EnMain_Rd) strobes++;
      if (wr ? EnMain_Rd : Mem_Wr) wrong++;
      if (Stall) stalls++; else done = 1;
      @(posedge CLK); #1;
    end
    $display("%s addr=0x%03h stall=%0d strobe=%0d", wr ? "WR" : "RD", addr, stalls, strobes);
    if (!done) begin compared++; mismatched++; $display("FAIL timeout addr=0x%03h: Stall still high after 20 cycles", addr); end
    check($sformatf("stall_cycles@%03h", addr), stalls, exp_stall);
    check($sformatf("strobe_cycles@%03h", addr), strobes, exp_strobe);
    check($sformatf("wrong_strobe@%03h", addr), wrong, 0);
    Cpu_Rd = 1'b0; Cpu_Wr = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    for (int i = 0; i < 1024; i++) mem[i] = 32'h1000 + i;
    mem[4] = 32'hA0; mem[5] = 32'hA1; mem[6] = 32'hA2; mem[7] = 32'hA3;
    repeat (2) @(posedge CLK);
    #1;
    check("reset_stall", Stall, 0);
    check("reset_enrd", EnMain_Rd, 0);
    check("reset_memwr", Mem_Wr, 0);
    check("reset_hits", Hit_Count, 0);
    check("reset_misses", Miss_Count, 0);
    rst_n = 1'b1;
    @(posedge CLK); #1;

    request(0, 10'h004, 0, 32'hA0, 3, 2);
    check("miss_count_1", Miss_Count, 1);
    request(0, 10'h006, 0, 32'hA2, 0, 0);
    check("hit_count_1", Hit_Count, 1);

    request(1, 10'h005, 32'h55, 0, 5, 4);
    check("mem5_written", mem[5], 32'h55);
    request(0, 10'h005, 0, 32'h55, 0, 0);
    check("hit_count_2", Hit_Count, 2);

    request(1, 10'h3FC, 32'hDEADBEEF, 0, 5, 4);
    check("mem3fc_written", mem[10'h3FC], 32'hDEADBEEF);
    request(0, 10'h3FC, 0, 32'hDEADBEEF, 3, 2);
    check("miss_count_2", Miss_Count, 2);

    request(0, 10'h084, 0, 32'h1084, 3, 2);
    request(0, 10'h004, 0, 32'hA0, 3, 2);
    check("miss_count_4", Miss_Count, 4);
    request(0, 10'h005, 0, 32'h55, 0, 0);
    check("hit_count_3", Hit_Count, 3);

    // Reset during cycle 2 of a read miss on a resident-index conflict.
    Cpu_Addr = 10'h084; Cpu_Rd = 1'b1;
    @(posedge CLK); #1;
    @(posedge CLK); #1;
    check("enrd_before_reset", EnMain_Rd, 1);
    rst_n = 1'b0; Cpu_Rd = 1'b0;
    #1;
    check("reset_mid_enrd", EnMain_Rd, 0);
    check("reset_mid_stall", Stall, 0);
    check("reset_mid_misses", Miss_Count, 0);
    @(posedge CLK); @(posedge CLK); #1;
    rst_n = 1'b1;
    @(posedge CLK); #1;
    request(0, 10'h005, 0, 32'h55, 3, 2);
    check("post_reset_misses", Miss_Count, 1);
    check("post_reset_hits", Hit_Count, 0);

    repeat (2) @(posedge CLK);
    check("scoreboard_empty", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
